// File: rtl/mem_log_ctrl_pkg.sv
// Shared definitions for the MEM_LOG sample-capture controller: GPIO op codes,
// FSM state encoding and default geometry.
package mem_log_ctrl_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF = 10;

  typedef enum logic [7:0] {
    MEM_LOG_START  = 8'h00,
    MEM_LOG_ABORT  = 8'h01,
    MEM_LOG_READ   = 8'h02,
    MEM_LOG_STATUS = 8'h03
  } mem_log_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } log_state_t;

endpackage

// File: rtl/mem_log_ctrl_if.sv
// Command/sample/readback bundle between the GPIO register file (master)
// and the sample-log capture controller (slave).
interface mem_log_ctrl_if
  import mem_log_ctrl_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
);

  logic                start;
  logic                abort;
  logic                trigger;
  logic [DATA_LEN-1:0] sample_in;
  logic                sample_valid;
  logic                rd_req;
  logic [ADDR_LEN-1:0] rd_addr;
  logic [DATA_LEN-1:0] rd_data;
  logic                rd_valid;
  logic                busy;
  logic                full;
  logic [ADDR_LEN:0]   wr_count;

  modport master (
    output start, abort, trigger, sample_in, sample_valid, rd_req, rd_addr,
    input  rd_data, rd_valid, busy, full, wr_count
  );

  modport slave (
    input  start, abort, trigger, sample_in, sample_valid, rd_req, rd_addr,
    output rd_data, rd_valid, busy, full, wr_count
  );

endinterface

// File: rtl/mem_log_ctrl_log_ram.sv
// Simple dual-port sample-log RAM: one write port, one registered read port.
// Contents are never reset.
module log_ram #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 10
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_waddr,
  input  logic [DATA_LEN-1:0] i_wdata,
  input  logic                i_re,
  input  logic [ADDR_LEN-1:0] i_raddr,
  output logic [DATA_LEN-1:0] o_rdata
);

  logic [DATA_LEN-1:0] r_mem [2**ADDR_LEN];
  logic [DATA_LEN-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_log_ctrl.sv
// MEM_LOG capture controller: records a window of datapath samples into log_ram,
// then serves single-address readback. Define MEM_LOG_TRIGGER_EN to add the ARMED state.
module mem_log_ctrl
  import mem_log_ctrl_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mem_log_ctrl_if.slave  bus
);

  localparam logic [ADDR_LEN:0] FULL_CNT = (ADDR_LEN+1)'(2**ADDR_LEN);
  localparam logic [ADDR_LEN:0] CNT_ONE  = (ADDR_LEN+1)'(1);

  log_state_t          r_state;
  logic                r_busy;
  logic                r_full;
  logic [ADDR_LEN:0]   r_wr_count;
  logic                r_rd_valid;
  logic                r_rd_hit;

  logic                w_we;
  logic [ADDR_LEN:0]   w_wr_count_nxt;
  logic                w_rd_acc;
  logic                w_rd_hit;
  logic [DATA_LEN-1:0] w_ram_q;

  assign w_we           = (r_state == ST_CAPTURE) && bus.sample_valid && (r_wr_count != FULL_CNT);
  assign w_wr_count_nxt = r_wr_count + CNT_ONE;
  assign w_rd_acc       = bus.rd_req && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_rd_hit       = {1'b0, bus.rd_addr} < r_wr_count;

  log_ram #(
    .DATA_LEN (DATA_LEN),
    .ADDR_LEN (ADDR_LEN)
  ) u_log_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_count[ADDR_LEN-1:0]),
    .i_wdata (bus.sample_in),
    .i_re    (w_rd_acc),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_wr_count <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b1;
`ifdef MEM_LOG_TRIGGER_EN
            r_state    <= ST_ARMED;
`else
            r_state    <= ST_CAPTURE;
`endif
          end
        end
        ST_ARMED: begin
`ifdef MEM_LOG_TRIGGER_EN
          // The trigger-cycle sample is deliberately not stored.
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.trigger) begin
            r_state <= ST_CAPTURE;
          end
`else
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`endif
        end
        ST_CAPTURE: begin
          if (w_we) r_wr_count <= w_wr_count_nxt;
          // A sample coinciding with abort is still written before stopping.
          if (w_we && (w_wr_count_nxt == FULL_CNT)) begin
            r_state <= ST_DONE;
            r_full  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (bus.abort) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read response: out-of-window addresses are masked to zero on the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_hit <= w_rd_hit;
    end
  end

  assign bus.rd_data  = r_rd_hit ? w_ram_q : '0;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = r_busy;
  assign bus.full     = r_full;
  assign bus.wr_count = r_wr_count;

endmodule
